serial_word_feeder: RTL

Upstream stage for the Moore "1011" sequence detector. Accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per clock, onto `serial_out`. `serial_out` drives the detector's `sequence_in` directly. Also counts completed words for software/bench correlation with detector hits.

---
 rtl/serial_word_feeder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// serial_word_feeder
// Upstream stage for the Moore "1011" sequence detector. Takes parallel words
// over a valid/ready handshake and shifts them out MSB-first, one bit per
// clock, on serial_out. words_sent counts fully transmitted words.
//
// Optional feature: define SERIAL_FEEDER_SKID_EN to add a one-entry hold
// buffer so back-to-back words stream without the idle gap bit.

module serial_word_feeder #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_bitCnt;
  logic               r_serialOut;
  logic               r_serialValid;
  logic [15:0]        r_wordsSent;

  logic               w_wordReady;
  logic               w_accept;
  logic               w_lastBit;
  logic               w_loadIn;
  logic               w_loadHold;

`ifdef SERIAL_FEEDER_SKID_EN
  logic [WIDTH-1:0]   r_hold;
  logic               r_holdFull;
  logic               w_toHold;
`endif

  // Ready depends only on registered state, and is forced low during reset.
`ifdef SERIAL_FEEDER_SKID_EN
  assign w_wordReady = reset_n & ~r_holdFull;
`else
  assign w_wordReady = reset_n & (r_state == IDLE);
`endif

  assign w_accept  = word_valid & w_wordReady;
  assign w_lastBit = (r_state == SHIFT) && (r_bitCnt == '0);

  // Next state and load decisions: where the next word (if any) comes from.
  always_comb begin
    w_nextState = r_state;
    w_loadIn    = 1'b0;
    w_loadHold  = 1'b0;
`ifdef SERIAL_FEEDER_SKID_EN
    w_toHold    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_loadIn    = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (w_lastBit) begin
`ifdef SERIAL_FEEDER_SKID_EN
          if (r_holdFull) begin
            w_loadHold  = 1'b1;
            w_nextState = SHIFT;
          end else if (w_accept) begin
            w_loadIn    = 1'b1;
            w_nextState = SHIFT;
          end else begin
            w_nextState = IDLE;
          end
`else
          w_nextState = IDLE;
`endif
        end else begin
`ifdef SERIAL_FEEDER_SKID_EN
          w_toHold = w_accept;
`endif
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Shift datapath: the MSB goes straight to the output register on a load,
  // so the first bit shows one cycle after the accept edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift       <= '0;
      r_bitCnt      <= '0;
      r_serialOut   <= IDLE_LEVEL;
      r_serialValid <= 1'b0;
      r_wordsSent   <= 16'h0000;
    end else begin
      if (w_loadIn) begin
        r_shift       <= {word_in[WIDTH-2:0], 1'b0};
        r_serialOut   <= word_in[WIDTH-1];
        r_serialValid <= 1'b1;
        r_bitCnt      <= CNT_W'(WIDTH - 1);
`ifdef SERIAL_FEEDER_SKID_EN
      end else if (w_loadHold) begin
        r_shift       <= {r_hold[WIDTH-2:0], 1'b0};
        r_serialOut   <= r_hold[WIDTH-1];
        r_serialValid <= 1'b1;
        r_bitCnt      <= CNT_W'(WIDTH - 1);
`endif
      end else if (w_lastBit) begin
        r_serialOut   <= IDLE_LEVEL;
        r_serialValid <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_serialOut   <= r_shift[WIDTH-1];
        r_shift       <= {r_shift[WIDTH-2:0], 1'b0};
        r_bitCnt      <= r_bitCnt - CNT_W'(1);
      end
      if (w_lastBit) begin
        r_wordsSent <= r_wordsSent + 16'd1;
      end
    end
  end

`ifdef SERIAL_FEEDER_SKID_EN
  // Hold buffer: captures a word accepted mid-word, drains at the last bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold     <= '0;
      r_holdFull <= 1'b0;
    end else begin
      if (w_toHold) begin
        r_hold     <= word_in;
        r_holdFull <= 1'b1;
      end else if (w_loadHold) begin
        r_holdFull <= 1'b0;
      end
    end
  end

  assign busy = (r_state == SHIFT) | r_holdFull;
`else
  assign busy = (r_state == SHIFT);
`endif

  assign word_ready   = w_wordReady;
  assign serial_out   = r_serialOut;
  assign serial_valid = r_serialValid;
  assign words_sent   = r_wordsSent;

  // w_loadHold is only ever set when the hold buffer exists.
`ifndef SERIAL_FEEDER_SKID_EN
  logic w_unusedLoadHold;
  assign w_unusedLoadHold = w_loadHold;
`endif

endmodule
